switch_mcu_imem: RTL and testbench
==================================

SWITCH_MCU_IMEM -- requirements
Module: switch_mcu_imem

Interface
REQ-001 Parameter: DEPTH_LOG2, default 10, word-address width; memory holds 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter: WAIT_STATES, default 1, range 0..15, number of hready-low cycles inserted in each OKAY data phase.
REQ-003 Port: in_clk, input, 1, single clock; all logic on rising edge.
REQ-004 Port: in_rst, input, 1, reset, asynchronous, active-low.
REQ-005 Port: in_load_valid, input, 1, load-port write strobe.
REQ-006 Port: in_load_addr, input, DEPTH_LOG2, load word address.
REQ-007 Port: in_load_data, input, 32, load word.
REQ-008 Port: in_load_last, input, 1, marks final load word; qualified by in_load_valid.
REQ-009 Port: out_init_done, output, 1, memory loaded; drives the fetch unit's in_init_done.
REQ-010 Ports: in_haddr, input, 32, AHB address; in_htrans, input, 2; in_hwrite, input, 1; in_hsize, input, 4; in_hburst, input, 3; in_hport, input, 4; in_hmastlock, input, 1 (in_hburst, in_hport and in_hmastlock are ignored).
REQ-011 Ports: out_hready, output, 1; out_hresp, output, 1 (0 OKAY, 1 ERROR); out_hrdata, output, 32.

Function
REQ-012 The transfer request SHALL be in_htrans != 0 while out_hready = 1, sampled on a rising edge (address phase).
REQ-013 The FSM SHALL use states INIT, IDLE, WAIT, DATA, ERR1, ERR2.
REQ-014 INIT: out_hready = 1, out_init_done = 0; each in_load_valid cycle SHALL write in_load_data to mem[in_load_addr]; in_load_valid with in_load_last SHALL move to IDLE and set out_init_done on the next edge.
REQ-015 out_init_done SHALL be sticky until reset; load-port activity outside INIT SHALL be ignored.
REQ-016 A request SHALL be an error if any of: state is INIT; in_haddr[1:0] != 0; in_haddr[31:2] >= 2^DEPTH_LOG2; in_hwrite = 1; in_hsize != 2.
REQ-017 Error: ERR1 (hready 0, hresp 1, hrdata 0), then ERR2 (hready 1, hresp 1, hrdata 0), then IDLE (INIT if out_init_done = 0).
REQ-018 Valid request: sync SRAM read of word in_haddr[DEPTH_LOG2+1:2] issued on the sampling edge; next state WAIT if WAIT_STATES > 0, else DATA.
REQ-019 WAIT: hready 0, hresp 0; a 4-bit down-counter loaded with WAIT_STATES-1 SHALL decrement each cycle; at 0 move to DATA.
REQ-020 DATA: hready 1, hresp 0, out_hrdata = read word for exactly this cycle; otherwise out_hrdata = 0.
REQ-021 A request sampled in DATA or ERR2 SHALL be accepted as a pipelined address phase with no idle cycle; in IDLE, accepted likewise.
REQ-022 OKAY read latency from sampling edge to hrdata-valid cycle SHALL be WAIT_STATES+1 cycles.
REQ-023 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-024 in_rst low SHALL asynchronously force state INIT, out_init_done 0, out_hready 1, out_hresp 0, out_hrdata 0, wait counter 0.
REQ-025 Reset mid-transfer (WAIT/DATA/ERR1) SHALL abort it with no further response; reset mid-load SHALL require a full reload.

Structure
REQ-026 Shared package switch_mcu_pkg SHALL hold HTRANS_IDLE, HSIZE_WORD = 2, HRESP_OKAY/HRESP_ERROR, and the FSM state encoding.
REQ-027 Storage SHALL be sub-module switch_mcu_sram_1rw (one port, synchronous write and read, read data one cycle after enable); load and AHB access are mutually exclusive by state.

Verification
REQ-028 Load mem[0] = 0x00000013, mem[1] = 0x00100093 with last on word 1 -> out_init_done = 1 on the next cycle.
REQ-029 WAIT_STATES = 1, read 0x4 -> hready 0 for one cycle, then hready 1, hresp 0, hrdata 0x00100093.
REQ-030 Read 0x2 and read 0x1000 (DEPTH_LOG2 = 10) -> each: ERR1 then ERR2, hresp 1, hrdata 0.
REQ-031 Request before out_init_done -> two-cycle ERROR; memory unchanged.
REQ-032 WAIT_STATES = 0, back-to-back reads 0x0, 0x4 -> hrdata 0x00000013 then 0x00100093 on consecutive cycles, hready held 1.
REQ-033 Assert in_rst during WAIT -> outputs at reset values immediately; after release out_init_done = 0 until reload.

Source files
------------

// File: rtl/switch_mcu_pkg.sv
// rtl/switch_mcu_pkg.sv - shared AHB encodings and FSM state codes for the MCU instruction memory
package switch_mcu_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [3:0] HSIZE_WORD  = 4'd2;
  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_ERR1 = 3'd4;
  localparam logic [2:0] ST_ERR2 = 3'd5;

  // Only aligned word reads inside the populated range are serviced; everything else errors.
  function automatic logic ahb_read_legal(
    input logic [31:0] haddr,
    input logic        hwrite,
    input logic [3:0]  hsize,
    input int          depth_log2
  );
    logic aligned;
    logic in_range;
    aligned  = (haddr[1:0] == 2'b00);
    in_range = ((haddr >> (depth_log2 + 2)) == 32'd0);
    return aligned && in_range && !hwrite && (hsize == HSIZE_WORD);
  endfunction

endpackage

// File: rtl/switch_mcu_sram_1rw.sv
// rtl/switch_mcu_sram_1rw.sv - single-port synchronous SRAM, read data valid one cycle after enable
module switch_mcu_sram_1rw #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              in_clk,
  input  logic              in_en,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic [DATA_W-1:0] out_rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  // No reset on the array or read register: contents survive a system reset.
  always_ff @(posedge in_clk) begin
    if (in_en) begin
      if (in_we) begin
        mem[in_addr] <= in_wdata;
      end else begin
        out_rdata <= mem[in_addr];
      end
    end
  end

endmodule

// File: rtl/switch_mcu_imem.sv
// rtl/switch_mcu_imem.sv - AHB-lite read-only instruction memory with a boot-time load port
module switch_mcu_imem
  import switch_mcu_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_load_valid,
  input  logic [DEPTH_LOG2-1:0] in_load_addr,
  input  logic [31:0]           in_load_data,
  input  logic                  in_load_last,
  output logic                  out_init_done,
  input  logic [31:0]           in_haddr,
  input  logic [1:0]            in_htrans,
  input  logic                  in_hwrite,
  input  logic [3:0]            in_hsize,
  input  logic [2:0]            in_hburst,
  input  logic [3:0]            in_hport,
  input  logic                  in_hmastlock,
  output logic                  out_hready,
  output logic                  out_hresp,
  output logic [31:0]           out_hrdata
);

  localparam logic [2:0] OKAY_NEXT = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [3:0]            wait_cnt;
  logic                  init_done;
  logic                  req;
  logic                  req_ok;
  logic                  req_err;
  logic                  load_wr;
  logic                  load_fin;
  logic                  ram_en;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [31:0]           ram_rdata;
  logic                  unused_ahb;

  assign unused_ahb = ^{in_hburst, in_hport, in_hmastlock};

  assign out_hready    = (state != ST_WAIT) && (state != ST_ERR1);
  assign out_hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign out_hrdata    = (state == ST_DATA) ? ram_rdata : 32'd0;
  assign out_init_done = init_done;

  // An unloaded memory rejects every request, including during the trailing error beat.
  assign req     = (in_htrans != HTRANS_IDLE) && out_hready;
  assign req_ok  = req && init_done && ahb_read_legal(in_haddr, in_hwrite, in_hsize, DEPTH_LOG2);
  assign req_err = req && !req_ok;

  assign load_wr  = (state == ST_INIT) && in_load_valid;
  assign load_fin = load_wr && in_load_last;

  assign ram_en   = load_wr || req_ok;
  assign ram_we   = (state == ST_INIT);
  assign ram_addr = (state == ST_INIT) ? in_load_addr : in_haddr[DEPTH_LOG2+1:2];

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT: begin
        if (req_err) begin
          state_nx = ST_ERR1;
        end else if (load_fin) begin
          state_nx = ST_IDLE;
        end
      end
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (req_err) begin
          state_nx = ST_ERR1;
        end else if (req_ok) begin
          state_nx = OKAY_NEXT;
        end else begin
          state_nx = init_done ? ST_IDLE : ST_INIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nx = ST_DATA;
        end
      end
      ST_ERR1: state_nx = ST_ERR2;
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state     <= ST_INIT;
      init_done <= 1'b0;
      wait_cnt  <= 4'd0;
    end else begin
      state <= state_nx;
      if (load_fin) begin
        init_done <= 1'b1;
      end
      if (req_ok) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  switch_mcu_sram_1rw #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (32)
  ) u_sram (
    .in_clk    (in_clk),
    .in_en     (ram_en),
    .in_we     (ram_we),
    .in_addr   (ram_addr),
    .in_wdata  (in_load_data),
    .out_rdata (ram_rdata)
  );

endmodule

// File: tb/tb_switch_mcu_imem.sv
// tb/tb_switch_mcu_imem.sv - self-checking bench for switch_mcu_imem with one and zero wait states
module tb_switch_mcu_imem;

  localparam int DL    = 10;
  localparam int WORDS = 1 << DL;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
  } ph_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic [DL-1:0] load_addr;
  logic [31:0]   load_data;
  logic          load_last;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [3:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hport;
  logic          hmastlock;
  logic          sel;

  logic        a_init_done, a_hready, a_hresp;
  logic [31:0] a_hrdata;
  logic        b_init_done, b_hready, b_hresp;
  logic [31:0] b_hrdata;
  logic [1:0]  a_htrans, b_htrans;

  logic        hready, hresp, init_done;
  logic [31:0] hrdata;
  logic [33:0] obs;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_model [WORDS];

  always #5 clk = ~clk;

  assign a_htrans  = sel ? 2'b00 : htrans;
  assign b_htrans  = sel ? htrans : 2'b00;
  assign hready    = sel ? b_hready : a_hready;
  assign hresp     = sel ? b_hresp : a_hresp;
  assign hrdata    = sel ? b_hrdata : a_hrdata;
  assign init_done = sel ? b_init_done : a_init_done;
  assign obs       = {hready, hresp, hrdata};

  switch_mcu_imem #(.DEPTH_LOG2(DL), .WAIT_STATES(1)) dut_a (
    .in_clk(clk), .in_rst(rst_n),
    .in_load_valid(load_valid), .in_load_addr(load_addr),
    .in_load_data(load_data), .in_load_last(load_last),
    .out_init_done(a_init_done),
    .in_haddr(haddr), .in_htrans(a_htrans), .in_hwrite(hwrite), .in_hsize(hsize),
    .in_hburst(hburst), .in_hport(hport), .in_hmastlock(hmastlock),
    .out_hready(a_hready), .out_hresp(a_hresp), .out_hrdata(a_hrdata)
  );

  switch_mcu_imem #(.DEPTH_LOG2(DL), .WAIT_STATES(0)) dut_b (
    .in_clk(clk), .in_rst(rst_n),
    .in_load_valid(load_valid), .in_load_addr(load_addr),
    .in_load_data(load_data), .in_load_last(load_last),
    .out_init_done(b_init_done),
    .in_haddr(haddr), .in_htrans(b_htrans), .in_hwrite(hwrite), .in_hsize(hsize),
    .in_hburst(hburst), .in_hport(hport), .in_hmastlock(hmastlock),
    .out_hready(b_hready), .out_hresp(b_hresp), .out_hrdata(b_hrdata)
  );

  function automatic bit legal(input logic [31:0] a, input logic wr, input logic [3:0] sz);
    return (a % 4 == 0) && (a / 4 < WORDS) && !wr && (sz == 4'd2);
  endfunction

  task automatic drive_req(input logic [31:0] a, input logic wr, input logic [3:0] sz);
    htrans    = 2'($urandom_range(1, 3));
    haddr     = a;
    hwrite    = wr;
    hsize     = sz;
    hburst    = 3'($urandom);
    hport     = 4'($urandom);
    hmastlock = 1'($urandom);
  endtask

  task automatic drive_idle();
    htrans = 2'b00;
    haddr  = $urandom;
    hwrite = 1'($urandom);
    hsize  = 4'($urandom);
  endtask

  task automatic do_load(input int a, input logic [31:0] d, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = DL'(a);
    load_data  = d;
    load_last  = last;
  endtask

  task automatic rand_req(output logic [31:0] a, output logic wr, output logic [3:0] sz);
    a  = $urandom_range(0, WORDS - 1) << 2;
    wr = 1'b0;
    sz = 4'd2;
    case ($urandom_range(0, 9))
      0: a = a | $urandom_range(1, 3);
      1: a = $urandom_range(WORDS, 32'h3FFF_FFFF) << 2;
      2: wr = 1'b1;
      3: begin
        sz = 4'($urandom_range(0, 15));
        if (sz == 4'd2) sz = 4'd3;
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    checks++;
    if ({a_init_done, b_init_done, a_hready, a_hresp, a_hrdata, b_hready, b_hresp, b_hrdata}
        !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_values: a done=%b rdy=%b resp=%b data=%h b done=%b rdy=%b resp=%b data=%h, want done 0 rdy 1 resp 0 data 0",
               a_init_done, a_hready, a_hresp, a_hrdata, b_init_done, b_hready, b_hresp, b_hrdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pre_init();
    ph_t exp [3];
    exp[0] = '{1'b0, 1'b1, 32'h0};
    exp[1] = '{1'b1, 1'b1, 32'h0};
    exp[2] = '{1'b1, 1'b0, 32'h0};
    sel = 1'b0;
    @(negedge clk);
    drive_req(32'h0, 1'b0, 4'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_idle();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL pre_init_err beat %0d: got rdy=%b resp=%b data=%h, want %b %b %h",
                 i, hready, hresp, hrdata, exp[i].rdy, exp[i].resp, exp[i].data);
      end
    end
    checks++;
    if (a_init_done !== 1'b0) begin
      errors++;
      $display("FAIL pre_init_done: got %b want 0", a_init_done);
    end
  endtask

  task automatic test_load();
    for (int i = 2; i < WORDS; i++) begin
      mem_model[i] = $urandom;
      do_load(i, mem_model[i], 1'b0);
    end
    mem_model[0] = 32'h0000_0013;
    mem_model[1] = 32'h0010_0093;
    do_load(0, 32'h0000_0013, 1'b0);
    do_load(1, 32'h0010_0093, 1'b1);
    checks++;
    if ({a_init_done, b_init_done} !== 2'b00) begin
      errors++;
      $display("FAIL init_done_early: got a=%b b=%b want 0 0", a_init_done, b_init_done);
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++;
    if ({a_init_done, b_init_done} !== 2'b11) begin
      errors++;
      $display("FAIL init_done_set: got a=%b b=%b want 1 1", a_init_done, b_init_done);
    end
  endtask

  task automatic test_load_ignored();
    do_load(0, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    sel = 1'b0;
    drive_req(32'h0, 1'b0, 4'd2);
    repeat (2) @(negedge clk);
    drive_idle();
    checks++;
    if ({obs, a_init_done} !== {1'b1, 1'b0, 32'h0000_0013, 1'b1}) begin
      errors++;
      $display("FAIL load_ignored: got rdy=%b resp=%b data=%h done=%b, want 1 0 00000013 1",
               hready, hresp, hrdata, a_init_done);
    end
  endtask

  task automatic test_read_ws1();
    sel = 1'b0;
    @(negedge clk);
    drive_req(32'h4, 1'b0, 4'd2);
    @(negedge clk);
    drive_idle();
    checks++;
    if (obs !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL ws1_wait: got rdy=%b resp=%b data=%h, want 0 0 00000000", hready, hresp, hrdata);
    end
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0010_0093}) begin
      errors++;
      $display("FAIL ws1_data: got rdy=%b resp=%b data=%h, want 1 0 00100093", hready, hresp, hrdata);
    end
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL ws1_after: got rdy=%b resp=%b data=%h, want 1 0 00000000", hready, hresp, hrdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] bad [2];
    bad[0] = 32'h2;
    bad[1] = 32'h1000;
    sel = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_req(bad[k], 1'b0, 4'd2);
      @(negedge clk);
      drive_idle();
      checks++;
      if (obs !== {1'b0, 1'b1, 32'h0}) begin
        errors++;
        $display("FAIL err1 addr %h: got rdy=%b resp=%b data=%h, want 0 1 00000000", bad[k], hready, hresp, hrdata);
      end
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 1'b1, 32'h0}) begin
        errors++;
        $display("FAIL err2 addr %h: got rdy=%b resp=%b data=%h, want 1 1 00000000", bad[k], hready, hresp, hrdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    @(negedge clk);
    drive_req(32'h0, 1'b0, 4'd2);
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0000_0013}) begin
      errors++;
      $display("FAIL b2b_first: got rdy=%b resp=%b data=%h, want 1 0 00000013", hready, hresp, hrdata);
    end
    drive_req(32'h4, 1'b0, 4'd2);
    @(negedge clk);
    drive_idle();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0010_0093}) begin
      errors++;
      $display("FAIL b2b_second: got rdy=%b resp=%b data=%h, want 1 0 00100093", hready, hresp, hrdata);
    end
  endtask

  task automatic test_random_stream(input bit use_b, input int n);
    ph_t q[$];
    ph_t exp;
    int issued = 0;
    int cyc = 0;
    int w;
    logic [31:0] a;
    logic wr;
    logic [3:0] sz;
    sel = use_b;
    w = use_b ? 0 : 1;
    while ((issued < n || q.size() != 0) && cyc < 40 * n) begin
      @(negedge clk);
      cyc++;
      exp = (q.size() != 0) ? q.pop_front() : ph_t'{1'b1, 1'b0, 32'h0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stream ws%0d cyc %0d: got rdy=%b resp=%b data=%h, want %b %b %h",
                 w, cyc, hready, hresp, hrdata, exp.rdy, exp.resp, exp.data);
      end
      if (exp.rdy && issued < n && $urandom_range(0, 3) != 0) begin
        rand_req(a, wr, sz);
        drive_req(a, wr, sz);
        issued++;
        if (legal(a, wr, sz)) begin
          repeat (w) q.push_back(ph_t'{1'b0, 1'b0, 32'h0});
          q.push_back(ph_t'{1'b1, 1'b0, mem_model[a[DL+1:2]]});
        end else begin
          q.push_back(ph_t'{1'b0, 1'b1, 32'h0});
          q.push_back(ph_t'{1'b1, 1'b1, 32'h0});
        end
      end else begin
        drive_idle();
      end
    end
    checks++;
    if (issued < n || q.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout ws%0d: issued %0d of %0d, %0d beats pending", w, issued, n, q.size());
    end
  endtask

  task automatic test_reset_in_wait();
    sel = 1'b0;
    @(negedge clk);
    drive_req(32'h8, 1'b0, 4'd2);
    @(negedge clk);
    drive_idle();
    checks++;
    if (hready !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_pre: got hready=%b want 0", hready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_hready, a_hresp, a_hrdata, a_init_done, b_init_done} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_async: got rdy=%b resp=%b data=%h done a=%b b=%b, want 1 0 00000000 0 0",
               a_hready, a_hresp, a_hrdata, a_init_done, b_init_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({obs, a_init_done} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
        errors++;
        $display("FAIL rst_aborted: got rdy=%b resp=%b data=%h done=%b, want 1 0 00000000 0",
                 hready, hresp, hrdata, a_init_done);
      end
    end
    test_pre_init();
    do_load(0, mem_model[0], 1'b0);
    do_load(1, mem_model[1], 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++;
    if ({a_init_done, b_init_done} !== 2'b11) begin
      errors++;
      $display("FAIL reload_done: got a=%b b=%b want 1 1", a_init_done, b_init_done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    sel        = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    load_last  = 1'b0;
    hburst     = '0;
    hport      = '0;
    hmastlock  = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    test_reset();
    test_pre_init();
    test_load();
    test_load_ignored();
    test_read_ws1();
    test_errors();
    test_back_to_back();
    test_random_stream(1'b0, 150);
    test_random_stream(1'b1, 150);
    test_reset_in_wait();
    test_random_stream(1'b0, 80);
    test_random_stream(1'b1, 80);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
